// File: rtl/regfile4_pkg.sv
// Shared sizing constants for the 4-entry register file.
// No logic; imported by the top and its cells.
package regfile4_pkg;
  localparam int REG_COUNT = 4;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/regfile4_decoder.sv
// Gate-level 2-to-4 write-enable decoder (one-hot when en is high, all zero otherwise).
// Purely combinational, zero latency, no backpressure.
module decoder2to4 (
  input  wire       en,
  input  wire [1:0] addr,
  output wire [3:0] sel
);
  wire na0;
  wire na1;

  not u_n0 (na0, addr[0]);
  not u_n1 (na1, addr[1]);

  and u_a0 (sel[0], en, na1,     na0);
  and u_a1 (sel[1], en, na1,     addr[0]);
  and u_a2 (sel[2], en, addr[1], na0);
  and u_a3 (sel[3], en, addr[1], addr[0]);
endmodule

// File: rtl/regfile4_mux4.sv
// One-bit 4:1 mux cell; sel1 is the LSB, sel2 the MSB of the index.
// Purely combinational, zero latency, no backpressure.
module mux4 (
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  input  logic sel1,
  input  logic sel2,
  output logic out
);
  always_comb begin
    case ({sel2, sel1})
      2'b00:   out = in1;
      2'b01:   out = in2;
      2'b10:   out = in3;
      default: out = in4;
    endcase
  end
endmodule

// File: rtl/regfile4.sv
// 4-entry register file: one write port, two async read ports, optional bypass and zero register.
// Reads are zero-latency; writes land on the rising edge; never stalls.
module regfile4
  import regfile4_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [CNT_W-1:0]  wr_count
);
  logic [REG_COUNT-1:0] wr_sel;
  logic [WIDTH-1:0]     regs [REG_COUNT];
  logic [WIDTH-1:0]     mux_a;
  logic [WIDTH-1:0]     mux_b;
  logic                 wr_accept;

  decoder2to4 u_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .sel  (wr_sel)
  );

  // Reset gates acceptance so bypass cannot leak wr_data while reset is held.
  assign wr_accept = wr_en && !reset && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_sel[i] && !(ZERO_REG && (i == 0))) regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wr_accept && (wr_count != CNT_MAX)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux4 u_mux_a (
      .in1  (regs[0][b]),
      .in2  (regs[1][b]),
      .in3  (regs[2][b]),
      .in4  (regs[3][b]),
      .sel1 (rd_addr_a[0]),
      .sel2 (rd_addr_a[1]),
      .out  (mux_a[b])
    );
    mux4 u_mux_b (
      .in1  (regs[0][b]),
      .in2  (regs[1][b]),
      .in3  (regs[2][b]),
      .in4  (regs[3][b]),
      .sel1 (rd_addr_b[0]),
      .sel2 (rd_addr_b[1]),
      .out  (mux_b[b])
    );
  end

  always_comb begin
    rd_data_a = mux_a;
    if (BYPASS && wr_accept && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (ZERO_REG && (rd_addr_a == '0)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = mux_b;
    if (BYPASS && wr_accept && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
    if (ZERO_REG && (rd_addr_b == '0)) rd_data_b = '0;
  end
endmodule
